// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave register responder.
// State encoding, byte length and address-byte R/W bit position.
package i2c_pkg;

    localparam int BIT_CNT = 8;
    localparam int RW_BIT  = 0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge, START and STOP detection.
// START/STOP qualify on SCL being high for two consecutive samples.
module i2c_line_sync (
    input  logic clockIn,
    input  logic reset_n,
    input  logic sclIn,
    input  logic sdaIn,
    output logic sclRise,
    output logic sclFall,
    output logic startDet,
    output logic stopDet,
    output logic sdaSync
);

    logic [1:0] r_scl;
    logic [1:0] r_sda;
    logic       r_sclD;
    logic       r_sdaD;
    logic       w_scl;
    logic       w_sda;

    always_ff @(posedge clockIn or negedge reset_n) begin
        if (!reset_n) begin
            r_scl  <= 2'b11;
            r_sda  <= 2'b11;
            r_sclD <= 1'b1;
            r_sdaD <= 1'b1;
        end else begin
            r_scl  <= {r_scl[0], sclIn};
            r_sda  <= {r_sda[0], sdaIn};
            r_sclD <= r_scl[1];
            r_sdaD <= r_sda[1];
        end
    end

    assign w_scl    = r_scl[1];
    assign w_sda    = r_sda[1];
    assign sclRise  = w_scl & ~r_sclD;
    assign sclFall  = ~w_scl & r_sclD;
    assign startDet = w_scl & r_sclD & r_sdaD & ~w_sda;
    assign stopDet  = w_scl & r_sclD & ~r_sdaD & w_sda;
    assign sdaSync  = w_sda;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave exposing an 8-bit register pointer with write/read strobes.
// Read support is built only when I2C_SLAVE_READ_EN is defined.
module i2c_slave_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h39,
    parameter int         REG_AW     = 8
) (
    input  logic              clockIn,
    input  logic              reset_n,
    input  logic              sclIn,
    input  logic              sdaIn,
    output logic              sdaPullLow,
    output logic [REG_AW-1:0] regAddr,
    output logic [7:0]        regWData,
    output logic              regWrite,
    input  logic [7:0]        regRData,
    output logic              regRead,
    output logic              busy
);

`ifdef I2C_SLAVE_READ_EN
    localparam logic L_RD = 1'b1;
`else
    localparam logic L_RD = 1'b0;
`endif
    localparam logic [3:0]        L_LAST = 4'(BIT_CNT);
    localparam logic [REG_AW-1:0] L_ONE  = REG_AW'(1);

    logic w_sclRise;
    logic w_sclFall;
    logic w_start;
    logic w_stop;
    logic w_sda;
    logic w_rx;
    logic w_match;
    logic [7:0] w_rdata;

    state_t            r_state;
    state_t            w_state;
    logic [3:0]        r_bitCnt;
    logic [3:0]        w_bitCnt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift;
    logic              r_pull;
    logic              w_pull;
    logic [REG_AW-1:0] r_addr;
    logic [REG_AW-1:0] w_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        w_wdata;
    logic              r_write;
    logic              w_write;
    logic              r_read;
    logic              w_read;
    logic              r_busy;
    logic              w_busy;

    i2c_line_sync u_sync (
        .clockIn (clockIn),
        .reset_n (reset_n),
        .sclIn   (sclIn),
        .sdaIn   (sdaIn),
        .sclRise (w_sclRise),
        .sclFall (w_sclFall),
        .startDet(w_start),
        .stopDet (w_stop),
        .sdaSync (w_sda)
    );

`ifdef I2C_SLAVE_READ_EN
    assign w_rdata = regRData;
    assign regRead = r_read;
`else
    logic w_unused;
    assign w_rdata  = 8'h00;
    assign regRead  = 1'b0;
    assign w_unused = ^{regRData, r_read};
`endif

    assign w_rx = (r_state == ST_ADDR) || (r_state == ST_REG)
               || (r_state == ST_WDATA) || (r_state == ST_RDATA_ACK);
    // A read request is only acknowledged when read support is built in.
    assign w_match = (r_shift[7:1] == SLAVE_ADDR)
                  && (L_RD || !r_shift[RW_BIT]);

    always_ff @(posedge clockIn or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_bitCnt <= 4'd0;
            r_shift  <= 8'h00;
            r_pull   <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 8'h00;
            r_write  <= 1'b0;
            r_read   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_bitCnt <= w_bitCnt;
            r_shift  <= w_shift;
            r_pull   <= w_pull;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_write  <= w_write;
            r_read   <= w_read;
            r_busy   <= w_busy;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_bitCnt = r_bitCnt;
        w_shift  = r_shift;
        w_pull   = r_pull;
        w_addr   = r_addr;
        w_wdata  = r_wdata;
        w_write  = 1'b0;
        w_read   = 1'b0;
        w_busy   = r_busy;
        if (r_write) begin
            w_addr = r_addr + L_ONE;
        end
        if (r_read) begin
            w_shift = w_rdata;
            w_pull  = ~w_rdata[7];
        end
        if (w_stop) begin
            w_state  = ST_IDLE;
            w_bitCnt = 4'd0;
            w_pull   = 1'b0;
            w_busy   = 1'b0;
        end else if (w_start) begin
            w_state  = ST_ADDR;
            w_bitCnt = 4'd0;
            w_pull   = 1'b0;
        end else begin
            if (w_sclRise && (w_rx || r_state == ST_RDATA)) begin
                w_bitCnt = r_bitCnt + 4'd1;
                if (w_rx) begin
                    w_shift = {r_shift[6:0], w_sda};
                end
            end
            unique case (r_state)
                ST_ADDR: begin
                    if (w_sclFall && r_bitCnt == L_LAST) begin
                        w_bitCnt = 4'd0;
                        if (w_match) begin
                            w_state = ST_ADDR_ACK;
                            w_pull  = 1'b1;
                            w_busy  = 1'b1;
                        end else begin
                            w_state = ST_IGNORE;
                            w_pull  = 1'b0;
                            w_busy  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_sclFall) begin
                        w_bitCnt = 4'd0;
                        w_pull   = 1'b0;
                        if (r_shift[RW_BIT]) begin
                            w_state = ST_RDATA;
                            w_read  = 1'b1;
                        end else begin
                            w_state = ST_REG;
                        end
                    end
                end
                ST_REG: begin
                    if (w_sclFall && r_bitCnt == L_LAST) begin
                        w_bitCnt = 4'd0;
                        w_addr   = REG_AW'(r_shift);
                        w_state  = ST_REG_ACK;
                        w_pull   = 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (w_sclFall && r_bitCnt == L_LAST) begin
                        w_bitCnt = 4'd0;
                        w_wdata  = r_shift;
                        w_write  = 1'b1;
                        w_state  = ST_WDATA_ACK;
                        w_pull   = 1'b1;
                    end
                end
                ST_REG_ACK, ST_WDATA_ACK: begin
                    if (w_sclFall) begin
                        w_bitCnt = 4'd0;
                        w_state  = ST_WDATA;
                        w_pull   = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (w_sclFall && r_bitCnt == L_LAST) begin
                        w_bitCnt = 4'd0;
                        w_state  = ST_RDATA_ACK;
                        w_pull   = 1'b0;
                    end else if (w_sclFall) begin
                        w_shift = {r_shift[6:0], 1'b0};
                        w_pull  = ~r_shift[6];
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_sclFall) begin
                        w_bitCnt = 4'd0;
                        if (!r_shift[0]) begin
                            w_state = ST_RDATA;
                            w_addr  = r_addr + L_ONE;
                            w_read  = 1'b1;
                        end else begin
                            w_state = ST_IGNORE;
                            w_busy  = 1'b0;
                        end
                    end
                end
                default: begin
                    w_pull = 1'b0;
                end
            endcase
        end
    end

    assign sdaPullLow = r_pull;
    assign regAddr    = r_addr;
    assign regWData   = r_wdata;
    assign regWrite   = r_write;
    assign busy       = r_busy;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bus-level bench for i2c_slave_responder: bit-banged master, register
// model for reads, and queues of expected write/read strobes.
module tb_i2c_slave_responder;
    import i2c_pkg::*;

    localparam int Q = 8;

    typedef struct {
        logic [7:0] dev;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       ack;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    wire        sda_line;
    logic       pull;
    logic       wr;
    logic       rd;
    logic       bsy;
    logic [7:0] raddr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    always #5 clk = ~clk;
    assign sda_line = m_sda & ~pull;

    i2c_slave_responder dut (
        .clockIn   (clk),
        .reset_n   (rst_n),
        .sclIn     (m_scl),
        .sdaIn     (sda_line),
        .sdaPullLow(pull),
        .regAddr   (raddr),
        .regWData  (wdata),
        .regWrite  (wr),
        .regRData  (rdata),
        .regRead   (rd),
        .busy      (bsy)
    );

    always_comb begin
        case (raddr)
            8'h20:   rdata = 8'h5A;
            8'h21:   rdata = 8'hC3;
            default: rdata = 8'hEE;
        endcase
    end

    logic [15:0] wr_log[$];
    logic [7:0]  rd_log[$];
    int          n_pull = 0;
    int          n_busy = 0;

    always @(negedge clk) begin
        if (wr) wr_log.push_back({raddr, wdata});
        if (rd) rd_log.push_back(raddr);
        if (pull) n_pull++;
        if (bsy) n_busy++;
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int          wr_i = 0;
    int          rd_i = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drain(input string nm);
        logic [15:0] ew;
        logic [7:0]  er;
        while (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            if (wr_i < wr_log.size()) begin
                chk({nm, " write"}, 32'(wr_log[wr_i]), 32'(ew));
                wr_i++;
            end else begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s write: got none expected %0h", nm, ew);
            end
        end
        while (exp_rd.size() > 0) begin
            er = exp_rd.pop_front();
            if (rd_i < rd_log.size()) begin
                chk({nm, " read"}, 32'(rd_log[rd_i]), 32'(er));
                rd_i++;
            end else begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s read: got none expected %0h", nm, er);
            end
        end
        chk({nm, " write count"}, 32'(wr_log.size()), 32'(wr_i));
        chk({nm, " read count"}, 32'(rd_log.size()), 32'(rd_i));
    endtask

    task automatic qw();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_sda = 1'b1; qw();
        m_scl = 1'b1; qw();
        m_sda = 1'b0; qw();
        m_scl = 1'b0; qw();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0; qw();
        m_scl = 1'b1; qw();
        m_sda = 1'b1; qw();
        qw();
    endtask

    task automatic put_bit(input logic b);
        m_sda = b; qw();
        m_scl = 1'b1; qw();
        qw();
        m_scl = 1'b0; qw();
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; qw();
        m_scl = 1'b1; qw();
        b = sda_line; qw();
        m_scl = 1'b0; qw();
    endtask

    task automatic put_byte(input logic [7:0] v, output logic a);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(b);
        a = ~b;
    endtask

    task automatic get_byte(output logic [7:0] v, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(~mack);
    endtask

    vec_t       tbl[5];
    logic       ack;
    logic [7:0] d;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] p8;
    int         p0;
    int         b0;

    initial begin
        tbl[0] = '{8'h72, 8'h10, 8'hAB, 1'b1};
        tbl[1] = '{8'h70, 8'h10, 8'h00, 1'b0};
        tbl[2] = '{8'h72, 8'h55, 8'h00, 1'b1};
        tbl[3] = '{8'h74, 8'h33, 8'h99, 1'b0};
        tbl[4] = '{8'h72, 8'h00, 8'hFF, 1'b1};
        m_addr  = 8'h00;
        m_wdata = 8'h00;

        rst_n = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset pull", 32'(pull), 32'(1'b0));
        chk("reset write", 32'(wr), 32'(1'b0));
        chk("reset read", 32'(rd), 32'(1'b0));
        chk("reset busy", 32'(bsy), 32'(1'b0));
        chk("reset regAddr", 32'(raddr), 32'(8'h00));
        chk("reset regWData", 32'(wdata), 32'(8'h00));
        chk("reset state", 32'(dut.r_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        qw();

        for (int i = 0; i < 5; i++) begin
            p0 = n_pull;
            b0 = n_busy;
            bus_start();
            put_byte(tbl[i].dev, ack);
            chk("addr ack", 32'(ack), 32'(tbl[i].ack));
            if (tbl[i].ack) begin
                chk("busy in xfer", 32'(bsy), 32'(1'b1));
                put_byte(tbl[i].ptr, ack);
                chk("ptr ack", 32'(ack), 32'(1'b1));
                exp_wr.push_back({tbl[i].ptr, tbl[i].data});
                put_byte(tbl[i].data, ack);
                chk("data ack", 32'(ack), 32'(1'b1));
                m_addr  = tbl[i].ptr + 8'h01;
                m_wdata = tbl[i].data;
            end
            bus_stop();
            drain("vec");
            chk("vec regAddr", 32'(raddr), 32'(m_addr));
            chk("vec busy idle", 32'(bsy), 32'(1'b0));
            chk("vec pull idle", 32'(pull), 32'(1'b0));
            if (!tbl[i].ack) begin
                chk("nomatch pull", 32'(n_pull - p0), 32'(0));
                chk("nomatch busy", 32'(n_busy - b0), 32'(0));
            end
        end

        bus_start();
        put_byte(8'h72, ack);
        chk("wrap addr ack", 32'(ack), 32'(1'b1));
        put_byte(8'hFF, ack);
        chk("wrap ptr ack", 32'(ack), 32'(1'b1));
        exp_wr.push_back({8'hFF, 8'h01});
        put_byte(8'h01, ack);
        chk("wrap d0 ack", 32'(ack), 32'(1'b1));
        exp_wr.push_back({8'h00, 8'h02});
        put_byte(8'h02, ack);
        chk("wrap d1 ack", 32'(ack), 32'(1'b1));
        bus_stop();
        drain("wrap");
        m_addr  = 8'h01;
        m_wdata = 8'h02;
        chk("wrap regAddr", 32'(raddr), 32'(m_addr));

        bus_start();
        put_byte(8'h72, ack);
        put_byte(8'h30, ack);
        chk("partial ptr ack", 32'(ack), 32'(1'b1));
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b1);
        put_bit(1'b1);
        bus_stop();
        drain("partial");
        m_addr = 8'h30;
        chk("partial regAddr", 32'(raddr), 32'(m_addr));
        chk("partial regWData", 32'(wdata), 32'(m_wdata));
        chk("partial pull", 32'(pull), 32'(1'b0));
        chk("partial busy", 32'(bsy), 32'(1'b0));
        chk("partial state", 32'(dut.r_state), 32'(ST_IDLE));

        bus_start();
        put_byte(8'h72, ack);
        p8 = 8'h40;
        for (int i = 7; i >= 0; i--) put_bit(p8[i]);
        m_sda = 1'b1; qw();
        m_scl = 1'b1; qw();
        chk("ack pulled", 32'(pull), 32'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("async release", 32'(pull), 32'(1'b0));
        chk("rst busy", 32'(bsy), 32'(1'b0));
        chk("rst state", 32'(dut.r_state), 32'(ST_IDLE));
        qw();
        m_scl = 1'b0; qw();
        rst_n = 1'b1;
        bus_stop();
        drain("midreset");
        m_addr  = 8'h00;
        m_wdata = 8'h00;
        chk("midreset regAddr", 32'(raddr), 32'(m_addr));
        chk("midreset regWData", 32'(wdata), 32'(m_wdata));
        chk("midreset state", 32'(dut.r_state), 32'(ST_IDLE));

`ifdef I2C_SLAVE_READ_EN
        bus_start();
        put_byte(8'h72, ack);
        put_byte(8'h20, ack);
        chk("rd ptr ack", 32'(ack), 32'(1'b1));
        exp_rd.push_back(8'h20);
        exp_rd.push_back(8'h21);
        bus_start();
        put_byte(8'h73, ack);
        chk("rd addr ack", 32'(ack), 32'(1'b1));
        chk("rd busy", 32'(bsy), 32'(1'b1));
        get_byte(d, 1'b1);
        chk("rd byte0", 32'(d), 32'(8'h5A));
        get_byte(d, 1'b0);
        chk("rd byte1", 32'(d), 32'(8'hC3));
        chk("rd ignore", 32'(dut.r_state), 32'(ST_IGNORE));
        chk("rd busy off", 32'(bsy), 32'(1'b0));
        chk("rd pull off", 32'(pull), 32'(1'b0));
        bus_stop();
        drain("read");
        chk("rd regAddr", 32'(raddr), 32'(8'h21));
`else
        p0 = n_pull;
        bus_start();
        put_byte(8'h73, ack);
        chk("rd nack", 32'(ack), 32'(1'b0));
        chk("rd busy", 32'(bsy), 32'(1'b0));
        chk("rd ignore", 32'(dut.r_state), 32'(ST_IGNORE));
        bus_stop();
        drain("noread");
        chk("noread pull", 32'(n_pull - p0), 32'(0));
        chk("noread regAddr", 32'(raddr), 32'(m_addr));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
